// File: rtl/demo_de0_sys_state_ram_pkg.sv
// Shared constants for the DE0 system state RAM and its write arbiter.
package demo_de0_sys_state_ram_pkg;

  localparam int unsigned STATE_RAM_ADDR_W = 1;
  localparam int unsigned STATE_RAM_DATA_W = 2;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demo_de0_sys_rr_select.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module demo_de0_sys_rr_select
  import demo_de0_sys_state_ram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [idx_width(NUM_REQ)-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0]                 grant_o
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_i) + k) % NUM_REQ;
      if (!found && req_i[IW'(idx)]) begin
        grant_o[IW'(idx)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demo_de0_sys_state_ram_arbiter.sv
// Round-robin arbiter feeding the state-RAM write port through one register slot.
// Define STATE_RAM_ARB_LOCK_EN to add req_lock (bounded repeat grants).
module demo_de0_sys_state_ram_arbiter
  import demo_de0_sys_state_ram_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = STATE_RAM_ADDR_W,
  parameter int unsigned DATA_W   = STATE_RAM_DATA_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
`ifdef STATE_RAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_W-1:0]             wr_address,
  output logic [DATA_W-1:0]             wr_writedata,
  output logic                          wr_write,
  input  logic                          wr_waitrequest,
  output logic [idx_width(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 1) begin : g_bad_param
    $error("demo_de0_sys_state_ram_arbiter: NUM_REQ must be 2..8, MAX_LOCK >= 1");
  end

  logic [ADDR_W-1:0]  wr_address_q, wr_address_d;
  logic [DATA_W-1:0]  wr_writedata_q, wr_writedata_d;
  logic               wr_write_q, wr_write_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      gidx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               slot_free;

  demo_de0_sys_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_oh)
  );

  // Free when empty or when the RAM takes the current beat this edge.
  assign slot_free = !wr_write_q || !wr_waitrequest;
  assign req_ready = (slot_free && !reset) ? grant_oh : '0;

  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        gidx     = IW'(i);
        sel_addr = req_address[i*ADDR_W +: ADDR_W];
        sel_data = req_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef STATE_RAM_ARB_LOCK_EN
  localparam int unsigned LW = idx_width(MAX_LOCK + 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d, lock_run;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic          locked;

  assign locked   = |(grant_oh & req_lock);
  assign lock_run = (lock_cnt_q != '0 && lock_id_q == gidx) ? lock_cnt_q + LW'(1) : LW'(1);
`endif

  always_comb begin
    wr_address_d   = wr_address_q;
    wr_writedata_d = wr_writedata_q;
    wr_write_d     = wr_write_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
`ifdef STATE_RAM_ARB_LOCK_EN
    lock_cnt_d     = lock_cnt_q;
    lock_id_d      = lock_id_q;
`endif
    if (slot_free) begin
      if (|grant_oh) begin
        wr_address_d   = sel_addr;
        wr_writedata_d = sel_data;
        wr_write_d     = 1'b1;
        grant_id_d     = gidx;
`ifdef STATE_RAM_ARB_LOCK_EN
        // A locked grant keeps last_grant so the same requester wins again,
        // until the run reaches MAX_LOCK and the pointer is forced forward.
        if (locked && lock_run != LW'(MAX_LOCK)) begin
          lock_cnt_d = lock_run;
          lock_id_d  = gidx;
        end else begin
          lock_cnt_d   = '0;
          last_grant_d = gidx;
        end
`else
        last_grant_d   = gidx;
`endif
      end else begin
        wr_write_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_address_q   <= '0;
      wr_writedata_q <= '0;
      wr_write_q     <= 1'b0;
      grant_id_q     <= '0;
      last_grant_q   <= IW'(NUM_REQ - 1);
`ifdef STATE_RAM_ARB_LOCK_EN
      lock_cnt_q     <= '0;
      lock_id_q      <= '0;
`endif
    end else begin
      wr_address_q   <= wr_address_d;
      wr_writedata_q <= wr_writedata_d;
      wr_write_q     <= wr_write_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
`ifdef STATE_RAM_ARB_LOCK_EN
      lock_cnt_q     <= lock_cnt_d;
      lock_id_q      <= lock_id_d;
`endif
    end
  end

  assign wr_address   = wr_address_q;
  assign wr_writedata = wr_writedata_q;
  assign wr_write     = wr_write_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_demo_de0_sys_state_ram_arbiter.sv
// Self-checking bench for demo_de0_sys_state_ram_arbiter (default parameters).
module tb_demo_de0_sys_state_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_address;
  logic [7:0] req_writedata;
  logic [3:0] req_ready;
  logic [0:0] wr_address;
  logic [1:0] wr_writedata;
  logic       wr_write;
  logic       wr_waitrequest;
  logic [1:0] grant_id;
`ifdef STATE_RAM_ARB_LOCK_EN
  logic [3:0] req_lock;
`endif

  int errors = 0;
  int checks = 0;

  demo_de0_sys_state_ram_arbiter #(
    .NUM_REQ  (4),
    .ADDR_W   (1),
    .DATA_W   (2),
    .MAX_LOCK (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
`ifdef STATE_RAM_ARB_LOCK_EN
    .req_lock       (req_lock),
`endif
    .req_address    (req_address),
    .req_writedata  (req_writedata),
    .req_ready      (req_ready),
    .wr_address     (wr_address),
    .wr_writedata   (wr_writedata),
    .wr_write       (wr_write),
    .wr_waitrequest (wr_waitrequest),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: slot contents plus round-robin pointer and lock run.
  int m_last = 3, m_addr = 0, m_data = 0, m_id = 0, m_cnt = 0, m_lockid = 0;
  bit m_v = 1'b0;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_advance(input int g);
`ifdef STATE_RAM_ARB_LOCK_EN
    int run;
    if (req_lock[g]) begin
      run = (m_cnt != 0 && m_lockid == g) ? m_cnt + 1 : 1;
      if (run >= 8) begin
        m_last = g;
        m_cnt  = 0;
      end else begin
        m_cnt    = run;
        m_lockid = g;
      end
    end else begin
      m_last = g;
      m_cnt  = 0;
    end
`else
    m_last = g;
`endif
  endtask

  task automatic model_cycle();
    logic [3:0] er;
    int         g;
    bit         free;
    #1;
    free = !m_v || !wr_waitrequest;
    g    = (reset || !free) ? -1 : pick(req_valid, m_last);
    er   = (g < 0) ? 4'b0000 : 4'(1 << g);
    check("model_ready", req_ready, er);
    if (reset) begin
      m_v = 0; m_addr = 0; m_data = 0; m_id = 0; m_last = 3; m_cnt = 0;
    end else if (free) begin
      if (g < 0) m_v = 0;
      else begin
        m_v    = 1;
        m_id   = g;
        m_addr = (req_address >> g) & 1;
        m_data = (req_writedata >> (2 * g)) & 3;
        model_advance(g);
      end
    end
    tick();
    check("model_wr_write", wr_write, m_v);
    check("model_grant_id", grant_id, m_id);
    check("model_wr_address", wr_address, m_addr);
    check("model_wr_writedata", wr_writedata, m_data);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic       wr;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[13];
`ifdef STATE_RAM_ARB_LOCK_EN
  int lock_exp[12] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 0};
`endif

  initial begin
    tbl[0]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b1010, 4'b1000, 1'b1, 2'd3};
    tbl[7]  = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    tbl[8]  = '{4'b1010, 4'b1000, 1'b1, 2'd3};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd3};
    tbl[10] = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{4'b0011, 4'b0001, 1'b1, 2'd0};
    tbl[12] = '{4'b0011, 4'b0010, 1'b1, 2'd1};

    reset          = 1'b1;
    req_valid      = 4'b0000;
    req_address    = 4'b1010;
    req_writedata  = 8'b11_10_01_00;
    wr_waitrequest = 1'b0;
`ifdef STATE_RAM_ARB_LOCK_EN
    req_lock       = 4'b0000;
`endif

    // Reset state
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_wr_write", wr_write, 1'b0);
    check("reset_wr_address", wr_address, 1'b0);
    check("reset_wr_writedata", wr_writedata, 2'd0);
    check("reset_grant_id", grant_id, 2'd0);

    // Table: one request pattern per cycle, pointer carried across rows
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid;
      #1;
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      tick();
      check($sformatf("tbl%0d_wr_write", i), wr_write, tbl[i].wr);
      check($sformatf("tbl%0d_grant_id", i), grant_id, tbl[i].gid);
      check($sformatf("tbl%0d_data", i), wr_writedata, tbl[i].gid);
      check($sformatf("tbl%0d_addr", i), wr_address, tbl[i].gid[0]);
    end

    // Clear sweep: stalled RAM after reset takes one beat and holds it
    reset          = 1'b1;
    wr_waitrequest = 1'b1;
    req_valid      = 4'b0001;
    tick();
    reset = 1'b0;
    #1;
    check("sweep_ready_first", req_ready, 4'b0001);
    tick();
    check("sweep_loaded", wr_write, 1'b1);
    check("sweep_gid", grant_id, 2'd0);
    check("sweep_ready_held0", req_ready, 4'b0000);
    tick();
    check("sweep_hold1", wr_write, 1'b1);
    check("sweep_ready_held1", req_ready, 4'b0000);
    tick();
    check("sweep_hold2", wr_write, 1'b1);
    req_valid      = 4'b0000;
    wr_waitrequest = 1'b0;
    #1;
    check("sweep_issue", wr_write, 1'b1);
    tick();
    check("sweep_drained", wr_write, 1'b0);

    // Reset while a stalled beat is held
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b1111;
    tick();
    wr_waitrequest = 1'b1;
    tick();
    check("midrst_held", wr_write, 1'b1);
    reset = 1'b1;
    tick();
    check("midrst_dropped", wr_write, 1'b0);
    reset          = 1'b0;
    wr_waitrequest = 1'b0;
    #1;
    check("midrst_ready0", req_ready, 4'b0001);
    tick();
    check("midrst_gid0", grant_id, 2'd0);
    check("midrst_write", wr_write, 1'b1);

`ifdef STATE_RAM_ARB_LOCK_EN
    // Locked requester 2 gets MAX_LOCK grants, then the pointer moves on
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_lock  = 4'b0100;
    for (int n = 0; n < 12; n++) begin
      tick();
      check($sformatf("lock_seq%0d", n), grant_id, lock_exp[n]);
    end
    req_lock = 4'b0000;
`endif

    // Model-checked: stall pulse mid-stream, then random traffic
    reset = 1'b1;
    model_cycle();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      wr_waitrequest = (c == 4 || c == 5);
      model_cycle();
    end
    for (int c = 0; c < 500; c++) begin
      reset          = ($urandom_range(0, 59) == 0);
      req_valid      = 4'($urandom);
      req_address    = 4'($urandom);
      req_writedata  = 8'($urandom);
      wr_waitrequest = ($urandom_range(0, 2) == 0);
`ifdef STATE_RAM_ARB_LOCK_EN
      req_lock       = 4'($urandom);
`endif
      model_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
